// File: rtl/sram_slot_arbiter_pkg.sv
// Shared constants and types for the Gigatron SRAM slot arbiter: slot phases,
// slot owners, lock-tracker states and the default starvation limit.
package sram_slot_arbiter_pkg;

  localparam logic [1:0] PH_A  = 2'd0;
  localparam logic [1:0] PH_B  = 2'd1;
  localparam logic [1:0] PH_G0 = 2'd2;
  localparam logic [1:0] PH_G1 = 2'd3;

  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    LK_SEARCH = 2'd0,
    LK_ONE    = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_e;

  // Fixed priority video > DMA, skipping a requester already holding a slot.
  function automatic owner_e pick_owner(input logic vid, input logic dma, input owner_e excl);
    if (vid && excl != OWN_VID) return OWN_VID;
    if (dma && excl != OWN_DMA) return OWN_DMA;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/sram_slot_arbiter_if.sv
// Requester and SRAM-side signals of the slot arbiter, bundled for port lists.
interface sram_slot_arbiter_if #(
  parameter int ADDR_W = 19
);
  // Handshake: a requester raises req with addr/we/wdata and holds all of them
  // stable until ack; ack is a single-cycle pulse carrying rdata, and completes
  // exactly one transfer. req still high in the ack cycle is a fresh request.
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic [7:0]        dma_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_drive;
  logic              ram_we_n;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  vid_req, vid_addr, dma_req, dma_we, dma_addr, dma_wdata, ram_din,
    output vid_ack, vid_rdata, dma_ack, dma_rdata,
    output ram_addr, ram_drive, ram_we_n, ram_dout
  );

  modport master (
    output vid_req, vid_addr, dma_req, dma_we, dma_addr, dma_wdata, ram_din,
    input  vid_ack, vid_rdata, dma_ack, dma_rdata,
    input  ram_addr, ram_drive, ram_we_n, ram_dout
  );

endinterface

// File: rtl/sram_slot_arbiter_tracker.sv
// Tracks the Gigatron clock: synchronises it, finds its rising edge, runs the
// mod-4 slot phase and decides whether the phase is locked to that edge.
module gclk_phase_tracker
  import sram_slot_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gclk_i,
  output logic [1:0]  phase_o,
  output logic        locked_o,
  output logic        locked_nxt_o,
  output lock_state_e state_o
);

  logic        sync1_q, sync2_q, sync3_q;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  gap_q, gap_d;
  lock_state_e state_q, state_d;
  logic        edge_det;
  logic        timeout;

  assign edge_det = sync2_q & ~sync3_q;
  // Eight consecutive edge-less cycles: the Gigatron clock has stopped.
  assign timeout  = !edge_det && (gap_q == 4'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      phase_q <= PH_A;
      gap_q   <= 4'd0;
      state_q <= LK_SEARCH;
    end else begin
      sync1_q <= gclk_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    phase_d = edge_det ? PH_A : phase_q + 2'd1;
    gap_d   = gap_q;
    if (edge_det)           gap_d = 4'd0;
    else if (gap_q != 4'd8) gap_d = gap_q + 4'd1;

    state_d = state_q;
    if (edge_det) begin
      if (phase_q != PH_G1) begin
        state_d = LK_SEARCH;
      end else begin
        case (state_q)
          LK_SEARCH: state_d = LK_ONE;
          LK_ONE:    state_d = LK_LOCKED;
          LK_LOCKED: state_d = LK_LOCKED;
          default:   state_d = LK_SEARCH;
        endcase
      end
    end else if (timeout) begin
      state_d = LK_SEARCH;
    end
  end

  always_comb begin
    phase_o      = phase_q;
    locked_o     = (state_q == LK_LOCKED);
    locked_nxt_o = (state_d == LK_LOCKED);
    state_o      = state_q;
  end

endmodule

// File: rtl/sram_slot_arbiter.sv
// Shares an SRAM between the Gigatron (phases 2-3) and two extension slots
// (phases 0-1) owned by a video fetcher and a DMA port.
module sram_slot_arbiter
  import sram_slot_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               CLKx4,
  input  logic               RST,
  input  logic               CLK,
  sram_slot_arbiter_if.slave bus,
  output logic               locked,
  output logic [1:0]         phase,
  output logic [3:0]         starve_cnt_o,
  output lock_state_e        lock_state_o
);

  logic [1:0]        phase_q;
  logic              locked_q, locked_nxt;
  lock_state_e       lock_state;

  owner_e            own_a, own_b;
  owner_e            own_b_q, own_b_d;
  owner_e            slot_own_q, slot_own_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_drive_q, ram_drive_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic              vid_ack_q, vid_ack_d, dma_ack_q, dma_ack_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d, dma_rdata_q, dma_rdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              starved, grant_go, slot_b_go, dma_granted;

  gclk_phase_tracker u_tracker (
    .clk_i        (CLKx4),
    .rst_i        (RST),
    .gclk_i       (CLK),
    .phase_o      (phase_q),
    .locked_o     (locked_q),
    .locked_nxt_o (locked_nxt),
    .state_o      (lock_state)
  );

  // Both slots are granted only while lock holds now and after this edge, so
  // a lock loss cancels slot B but never cuts short a slot already running.
  assign grant_go    = locked_q && locked_nxt && (phase_q == PH_G1);
  assign slot_b_go   = locked_q && locked_nxt && (phase_q == PH_A);
  assign starved     = ({28'd0, starve_q} >= 32'(STARVE_LIMIT));
  assign dma_granted = grant_go && (own_a == OWN_DMA || own_b == OWN_DMA);

  always_comb begin
    own_a = pick_owner(bus.vid_req, bus.dma_req, OWN_NONE);
    if (starved && bus.dma_req && own_a != OWN_DMA) own_b = OWN_DMA;
    else                                              own_b = pick_owner(bus.vid_req, bus.dma_req, own_a);
  end

  always_comb begin
    own_b_d = own_b_q;
    if (phase_q == PH_G1) own_b_d = grant_go ? own_b : OWN_NONE;

    slot_own_d = OWN_NONE;
    if (grant_go)       slot_own_d = own_a;
    else if (slot_b_go) slot_own_d = own_b_q;

    ram_drive_d = (slot_own_d != OWN_NONE);
    ram_we_n_d  = !(slot_own_d == OWN_DMA && bus.dma_we);
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    case (slot_own_d)
      OWN_VID: ram_addr_d = bus.vid_addr;
      OWN_DMA: begin
        ram_addr_d = bus.dma_addr;
        ram_dout_d = bus.dma_wdata;
      end
      default: ;
    endcase

    // Ack lands one cycle after the slot, with the byte sampled as it closes.
    vid_ack_d   = (slot_own_q == OWN_VID);
    dma_ack_d   = (slot_own_q == OWN_DMA);
    vid_rdata_d = (slot_own_q == OWN_VID) ? bus.ram_din : vid_rdata_q;
    dma_rdata_d = (slot_own_q == OWN_DMA && ram_we_n_q) ? bus.ram_din : dma_rdata_q;

    starve_d = starve_q;
    if (!bus.dma_req || dma_granted)                  starve_d = 4'd0;
    else if (phase_q == PH_G1 && starve_q != 4'hF)    starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge CLKx4) begin
    if (RST) begin
      own_b_q     <= OWN_NONE;
      slot_own_q  <= OWN_NONE;
      ram_addr_q  <= '0;
      ram_dout_q  <= 8'h00;
      ram_drive_q <= 1'b0;
      ram_we_n_q  <= 1'b1;
      vid_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      vid_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
      starve_q    <= 4'd0;
    end else begin
      own_b_q     <= own_b_d;
      slot_own_q  <= slot_own_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_drive_q <= ram_drive_d;
      ram_we_n_q  <= ram_we_n_d;
      vid_ack_q   <= vid_ack_d;
      dma_ack_q   <= dma_ack_d;
      vid_rdata_q <= vid_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_drive = ram_drive_q;
  assign bus.ram_we_n  = ram_we_n_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.dma_rdata = dma_rdata_q;

  assign locked        = locked_q;
  assign phase         = phase_q;
  assign starve_cnt_o  = starve_q;
  assign lock_state_o  = lock_state;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter: lock tracking, video/DMA slots,
// starvation, reset mid-slot and the Gigatron-phase bus rule.
module tb_sram_slot_arbiter;
  import sram_slot_arbiter_pkg::*;

  logic        clkx4 = 1'b0;
  logic        rst   = 1'b1;
  logic        gclk  = 1'b0;
  logic        locked;
  logic [1:0]  phase;
  logic [3:0]  starve_cnt;
  lock_state_e lock_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          gcnt     = 0;
  bit          gclk_run  = 1'b0;
  bit          gclk_skip = 1'b0;
  logic [7:0]  exp_q[$];

  sram_slot_arbiter_if #(.ADDR_W(19)) bus ();

  sram_slot_arbiter #(.ADDR_W(19), .STARVE_LIMIT(8)) dut (
    .CLKx4        (clkx4),
    .RST          (rst),
    .CLK          (gclk),
    .bus          (bus),
    .locked       (locked),
    .phase        (phase),
    .starve_cnt_o (starve_cnt),
    .lock_state_o (lock_state)
  );

  function automatic logic [7:0] sram_model(input logic [18:0] a);
    if (a == 19'h12345) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  assign bus.ram_din = sram_model(bus.ram_addr);

  // clock and reset block
  initial forever #5 clkx4 = ~clkx4;

  // Gigatron clock: period of four CLKx4 cycles; a skip delays it by one cycle.
  initial begin
    forever begin
      @(negedge clkx4);
      if (gclk_run) begin
        if (gclk_skip) gclk_skip = 1'b0;
        else           gcnt++;
      end
      gclk = gcnt[1];
    end
  end

  // driver tasks
  task automatic wait_phase(input logic [1:0] p);
    int n;
    n = 0;
    @(negedge clkx4);
    while (phase !== p && n < 16) begin
      @(negedge clkx4);
      n++;
    end
    if (phase !== p) begin
      n_checks++; n_fail++;
      $display("FAIL wait_phase: phase %0d, wanted %0d", phase, p);
    end
  endtask

  task automatic wait_lock(input int bound, output int n);
    n = 0;
    while (locked !== 1'b1 && n < bound) begin
      @(negedge clkx4);
      n++;
    end
  endtask

  task automatic test_reset;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clkx4);
    n_checks++; if (phase !== 2'd0)      begin n_fail++; $display("FAIL rst_phase: got %0d want 0", phase); end
    n_checks++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL rst_locked: got %0b want 0", locked); end
    n_checks++; if (starve_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_starve: got %0d want 0", starve_cnt); end
    n_checks++; if (bus.ram_drive !== 1'b0 || bus.ram_we_n !== 1'b1)
      begin n_fail++; $display("FAIL rst_ram_ctl: drive %0b we_n %0b want 0/1", bus.ram_drive, bus.ram_we_n); end
    n_checks++; if (bus.ram_addr !== 19'h0 || bus.ram_dout !== 8'h00)
      begin n_fail++; $display("FAIL rst_ram_bus: addr %h dout %h want 0/0", bus.ram_addr, bus.ram_dout); end
    n_checks++; if (bus.vid_ack !== 1'b0 || bus.dma_ack !== 1'b0)
      begin n_fail++; $display("FAIL rst_acks: vid %0b dma %0b want 0/0", bus.vid_ack, bus.dma_ack); end
    n_checks++; if (bus.vid_rdata !== 8'h00 || bus.dma_rdata !== 8'h00)
      begin n_fail++; $display("FAIL rst_rdata: vid %h dma %h want 0/0", bus.vid_rdata, bus.dma_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    int n;
    int bad;
    gclk_run = 1'b1;
    wait_lock(60, n);
    n_checks++; if (locked !== 1'b1)   begin n_fail++; $display("FAIL lock_acquire: locked %0b want 1", locked); end
    n_checks++; if (phase !== PH_A)    begin n_fail++; $display("FAIL lock_phase: phase %0d want 0", phase); end
    n_checks++; if (lock_state !== LK_LOCKED) begin n_fail++; $display("FAIL lock_state: got %0d want %0d", lock_state, LK_LOCKED); end
    bad = 0;
    repeat (20) begin @(negedge clkx4); if (locked !== 1'b1) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lock_stable: %0d unlocked cycles want 0", bad); end
    // delay the Gigatron edge by one cycle
    gclk_skip = 1'b1;
    n = 0;
    while (locked !== 1'b0 && n < 12) begin @(negedge clkx4); n++; end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_drop: locked %0b want 0", locked); end
    n = 0;
    while (locked === 1'b0 && n < 20) begin n++; @(negedge clkx4); end
    n_checks++; if (n != 8) begin n_fail++; $display("FAIL lock_relock_gap: %0d low cycles want 8", n); end
    n_checks++; if (locked !== 1'b1 || phase !== PH_A)
      begin n_fail++; $display("FAIL lock_relock: locked %0b phase %0d want 1/0", locked, phase); end
    // stop the Gigatron clock: lock must time out
    gclk_run = 1'b0;
    n = 0;
    while (locked === 1'b1 && n < 16) begin @(negedge clkx4); n++; end
    n_checks++; if (locked !== 1'b0 || lock_state !== LK_SEARCH)
      begin n_fail++; $display("FAIL lock_timeout: locked %0b state %0d want 0/%0d", locked, lock_state, LK_SEARCH); end
    gclk_run = 1'b1;
    wait_lock(60, n);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_restart: locked %0b want 1", locked); end
  endtask

  task automatic test_video_read;
    wait_phase(PH_G0);
    bus.vid_req = 1'b1; bus.vid_addr = 19'h12345;
    wait_phase(PH_A);
    n_checks++; if (bus.ram_drive !== 1'b1 || bus.ram_we_n !== 1'b1)
      begin n_fail++; $display("FAIL vid_slot_ctl: drive %0b we_n %0b want 1/1", bus.ram_drive, bus.ram_we_n); end
    n_checks++; if (bus.ram_addr !== 19'h12345) begin n_fail++; $display("FAIL vid_slot_addr: got %h want 12345", bus.ram_addr); end
    @(negedge clkx4);
    n_checks++; if (bus.vid_ack !== 1'b1 || phase !== PH_B)
      begin n_fail++; $display("FAIL vid_ack: ack %0b phase %0d want 1/1", bus.vid_ack, phase); end
    n_checks++; if (bus.vid_rdata !== 8'hA5) begin n_fail++; $display("FAIL vid_rdata: got %h want a5", bus.vid_rdata); end
    n_checks++; if (bus.ram_drive !== 1'b0) begin n_fail++; $display("FAIL vid_slot_b_idle: drive %0b want 0", bus.ram_drive); end
    bus.vid_req = 1'b0;
    @(negedge clkx4);
    n_checks++; if (bus.vid_ack !== 1'b0) begin n_fail++; $display("FAIL vid_ack_pulse: ack %0b want 0", bus.vid_ack); end
  endtask

  task automatic test_dma_write;
    wait_phase(PH_G0);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 19'h7FFFF; bus.dma_wdata = 8'h3C;
    wait_phase(PH_A);
    n_checks++; if (bus.ram_we_n !== 1'b0 || bus.ram_drive !== 1'b1)
      begin n_fail++; $display("FAIL dma_wr_ctl: we_n %0b drive %0b want 0/1", bus.ram_we_n, bus.ram_drive); end
    n_checks++; if (bus.ram_addr !== 19'h7FFFF || bus.ram_dout !== 8'h3C)
      begin n_fail++; $display("FAIL dma_wr_bus: addr %h dout %h want 7ffff/3c", bus.ram_addr, bus.ram_dout); end
    @(negedge clkx4);
    n_checks++; if (bus.ram_we_n !== 1'b1) begin n_fail++; $display("FAIL dma_wr_we_end: we_n %0b want 1", bus.ram_we_n); end
    n_checks++; if (bus.dma_ack !== 1'b1 || phase !== PH_B)
      begin n_fail++; $display("FAIL dma_wr_ack: ack %0b phase %0d want 1/1", bus.dma_ack, phase); end
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    @(negedge clkx4);
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_wr_pulse: ack %0b want 0", bus.dma_ack); end
  endtask

  task automatic test_back_to_back;
    wait_phase(PH_G0);
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00010;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 19'h00123;
    wait_phase(PH_A);
    n_checks++; if (bus.ram_addr !== 19'h00010) begin n_fail++; $display("FAIL b2b_slot_a: addr %h want 00010", bus.ram_addr); end
    @(negedge clkx4);
    n_checks++; if (bus.ram_addr !== 19'h00123 || bus.ram_drive !== 1'b1)
      begin n_fail++; $display("FAIL b2b_slot_b: addr %h drive %0b want 00123/1", bus.ram_addr, bus.ram_drive); end
    n_checks++; if (bus.vid_ack !== 1'b1 || bus.vid_rdata !== 8'h4A)
      begin n_fail++; $display("FAIL b2b_vid: ack %0b rdata %h want 1/4a", bus.vid_ack, bus.vid_rdata); end
    bus.vid_req = 1'b0;
    @(negedge clkx4);
    n_checks++; if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 8'h79)
      begin n_fail++; $display("FAIL b2b_dma: ack %0b rdata %h want 1/79", bus.dma_ack, bus.dma_rdata); end
    n_checks++; if (bus.ram_drive !== 1'b0) begin n_fail++; $display("FAIL b2b_g_phase: drive %0b want 0", bus.ram_drive); end
    bus.dma_req = 1'b0;
  endtask

  task automatic test_starvation;
    int n;
    int vid_acks;
    int dma_acks;
    int bad;
    // let lock time out, then pile up DMA wait while no slots exist
    gclk_run = 1'b0;
    n = 0;
    while (locked === 1'b1 && n < 16) begin @(negedge clkx4); n++; end
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00077;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 19'h00456;
    bad = 0;
    repeat (80) begin @(negedge clkx4); if (bus.vid_ack !== 1'b0 || bus.dma_ack !== 1'b0) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL starve_no_ack_unlocked: %0d acks want 0", bad); end
    n_checks++; if (starve_cnt !== 4'd15) begin n_fail++; $display("FAIL starve_saturate: got %0d want 15", starve_cnt); end
    gclk_run = 1'b1;
    n = 0; dma_acks = 0;
    while (dma_acks == 0 && n < 120) begin
      @(negedge clkx4);
      n++;
      if (bus.vid_ack === 1'b1) bus.vid_req = 1'b0;
      if (bus.dma_ack === 1'b1) begin
        dma_acks++;
        n_checks++; if (phase !== PH_G0 || bus.dma_rdata !== 8'h0C)
          begin n_fail++; $display("FAIL starve_dma_slot_b: phase %0d rdata %h want 2/0c", phase, bus.dma_rdata); end
        n_checks++; if (starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", starve_cnt); end
        bus.dma_req = 1'b0;
      end
    end
    n_checks++; if (dma_acks != 1) begin n_fail++; $display("FAIL starve_dma_served: %0d acks want 1", dma_acks); end
    bus.vid_req = 1'b0; bus.dma_req = 1'b0;
    // both requesters held: DMA still gets slot B every Gigatron cycle
    wait_phase(PH_G0);
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00200;
    bus.dma_req = 1'b1; bus.dma_addr = 19'h00300;
    vid_acks = 0; dma_acks = 0; bad = 0;
    repeat (24) begin
      @(negedge clkx4);
      if (bus.vid_ack === 1'b1) vid_acks++;
      if (bus.dma_ack === 1'b1) dma_acks++;
      if (starve_cnt !== 4'd0) bad++;
    end
    bus.vid_req = 1'b0; bus.dma_req = 1'b0;
    n_checks++; if (vid_acks != 6 || dma_acks != 6)
      begin n_fail++; $display("FAIL held_both_acks: vid %0d dma %0d want 6/6", vid_acks, dma_acks); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL held_both_starve: %0d nonzero cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_slot;
    int n;
    int bad;
    wait_phase(PH_G0);
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00ABC;
    wait_phase(PH_A);
    n_checks++; if (bus.ram_drive !== 1'b1) begin n_fail++; $display("FAIL rms_slot_live: drive %0b want 1", bus.ram_drive); end
    rst = 1'b1;
    @(negedge clkx4);
    n_checks++; if (bus.ram_drive !== 1'b0 || locked !== 1'b0 || bus.vid_ack !== 1'b0)
      begin n_fail++; $display("FAIL rms_after: drive %0b locked %0b ack %0b want 0/0/0", bus.ram_drive, locked, bus.vid_ack); end
    @(negedge clkx4);
    n_checks++; if (bus.vid_ack !== 1'b0) begin n_fail++; $display("FAIL rms_no_ack: ack %0b want 0", bus.vid_ack); end
    rst = 1'b0; bus.vid_req = 1'b0;
    n = 0; bad = 0;
    while (locked !== 1'b1 && n < 60) begin
      @(negedge clkx4);
      n++;
      if (locked !== 1'b1 && (bus.ram_drive !== 1'b0 || bus.vid_ack !== 1'b0)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rms_grant_unlocked: %0d cycles want 0", bad); end
    n_checks++; if (locked !== 1'b1 || n < 5)
      begin n_fail++; $display("FAIL rms_relock: locked %0b after %0d cycles want 1 after >=5", locked, n); end
    // requester re-issues the dropped read
    wait_phase(PH_G0);
    bus.vid_req = 1'b1;
    wait_phase(PH_B);
    n_checks++; if (bus.vid_ack !== 1'b1 || bus.vid_rdata !== 8'hE6)
      begin n_fail++; $display("FAIL rms_reissue: ack %0b rdata %h want 1/e6", bus.vid_ack, bus.vid_rdata); end
    bus.vid_req = 1'b0;
  endtask

  // scoreboard: video reads pushed to exp_q at issue and popped at ack
  task automatic test_random_phases;
    logic [7:0]  exp_b;
    logic [7:0]  dma_exp;
    logic [18:0] a;
    exp_q.delete();
    dma_exp = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clkx4);
      n_checks++;
      if (phase >= 2'd2 && (bus.ram_drive !== 1'b0 || bus.ram_we_n !== 1'b1)) begin
        n_fail++; $display("FAIL g_phase_bus: phase %0d drive %0b we_n %0b want 0/1", phase, bus.ram_drive, bus.ram_we_n);
      end
      if (bus.vid_ack === 1'b1) begin
        n_checks++;
        if (bus.vid_req !== 1'b1 || exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_vid_spurious: ack with req %0b", bus.vid_req);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.vid_rdata !== exp_b) begin n_fail++; $display("FAIL rnd_vid_rdata: got %h want %h", bus.vid_rdata, exp_b); end
        end
        bus.vid_req = 1'b0;
      end
      if (bus.dma_ack === 1'b1) begin
        n_checks++;
        if (bus.dma_req !== 1'b1) begin
          n_fail++; $display("FAIL rnd_dma_spurious: ack with req %0b", bus.dma_req);
        end else if (bus.dma_we === 1'b0 && bus.dma_rdata !== dma_exp) begin
          n_fail++; $display("FAIL rnd_dma_rdata: got %h want %h", bus.dma_rdata, dma_exp);
        end
        bus.dma_req = 1'b0;
      end
      if (phase == PH_G0 && c < 380) begin
        if (bus.vid_req == 1'b0 && $urandom_range(0, 1) == 1) begin
          a = 19'($urandom_range(0, 32'h7FFFF));
          bus.vid_addr = a; bus.vid_req = 1'b1;
          exp_q.push_back(sram_model(a));
        end
        if (bus.dma_req == 1'b0 && $urandom_range(0, 1) == 1) begin
          a = 19'($urandom_range(0, 32'h7FFFF));
          bus.dma_addr = a; bus.dma_we = 1'($urandom_range(0, 1));
          bus.dma_wdata = 8'($urandom_range(0, 255));
          dma_exp = sram_model(a);
          bus.dma_req = 1'b1;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0 || bus.vid_req !== 1'b0 || bus.dma_req !== 1'b0)
      begin n_fail++; $display("FAIL rnd_drain: %0d reads pending, vid_req %0b dma_req %0b", exp_q.size(), bus.vid_req, bus.dma_req); end
  endtask

  // final report
  initial begin
    test_reset();
    test_lock();
    test_video_read();
    test_dma_write();
    test_back_to_back();
    test_starvation();
    test_reset_mid_slot();
    test_random_phases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_slot_arbiter.md
SRAM_SLOT_ARBITER -- requirements
Module: sram_slot_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 19, the SRAM address width.
REQ-002 SHALL take parameter STARVE_LIMIT, default 8, the number of Gigatron cycles a pending DMA request may wait before it is forced into a slot.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 CLKx4  in  1  sole clock, four periods per Gigatron cycle.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 CLK  in  1  Gigatron clock, sampled as data for phase alignment only.
REQ-007 vid_req, vid_addr  in  1, ADDR_W  video fetch request and its read address.
REQ-008 vid_ack, vid_rdata  out  1, 8  one-cycle completion pulse and the returned byte.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata  in  1, 1, ADDR_W, 8  DMA request, its direction, its address and its write data.
REQ-010 dma_ack, dma_rdata  out  1, 8  one-cycle completion pulse and the returned read byte.
REQ-011 ram_addr, ram_drive, ram_we_n, ram_dout  out  ADDR_W, 1, 1, 8  SRAM address, address-bus drive enable, write strobe and write data.
REQ-012 ram_din  in  8  SRAM read data.
REQ-013 locked, phase  out  1, 2  phase lock status and the current slot phase.

Function
REQ-014 SHALL pass CLK through a two-flop synchroniser and detect its rising edge.
REQ-015 SHALL run phase as a mod-4 counter. On a detected edge the next phase SHALL be 0.
REQ-016 SHALL assert locked after two consecutive edges that each coincide with an expected wrap from 3 to 0.
REQ-017 SHALL deassert locked on any edge arriving at a phase other than 3, or when 8 cycles pass with no edge.
REQ-018 Phases 0 and 1 are extension slots A and B. Phases 2 and 3 belong to the Gigatron.
REQ-019 During Gigatron phases, ram_drive SHALL be 0 and ram_we_n SHALL be 1.
REQ-020 The owners of slots A and B SHALL be decided on the cycle where phase is 3, using the request state sampled in that cycle.
REQ-021 Slot A SHALL go to video if vid_req is set, else to DMA if dma_req is set, else stay idle.
REQ-022 Slot B SHALL go to DMA if starve_cnt is at least STARVE_LIMIT and dma_req is set.
REQ-023 Otherwise slot B SHALL use the same priority as slot A, excluding any requester already served in slot A.
REQ-024 While locked is 0, SHALL grant no slot.
REQ-025 Each owned slot lasts exactly one cycle. ram_addr, ram_dout and ram_we_n SHALL be registered at the edge that enters the slot, and ram_drive SHALL be 1.
REQ-026 ram_we_n SHALL be 0 only for a DMA write slot.
REQ-027 In an idle slot, ram_drive SHALL be 0 and ram_we_n SHALL be 1.
REQ-028 SHALL capture ram_din at the edge that ends a read slot.
REQ-029 SHALL pulse the owner's ack for exactly one cycle, the cycle after its slot, with rdata valid in that same cycle. Read latency is therefore slot + 1.
REQ-030 Requesters SHALL hold req, addr, we and wdata stable until ack.
REQ-031 Deasserting req before ack is illegal. The arbiter SHALL still complete any already-granted slot.
REQ-032 Each req/ack pair SHALL carry exactly one transfer. A request still set in the ack cycle is a new request.
REQ-033 starve_cnt (4 bits, saturating) SHALL increment at phase 3 while dma_req is set and DMA received no slot in the last cycle. It SHALL clear when DMA is granted or dma_req is 0.
REQ-034 Holding vid_req continuously SHALL NOT starve DMA beyond STARVE_LIMIT+1 Gigatron cycles.
REQ-035 If locked drops, any slots not yet executed SHALL be cancelled with no ack. A slot in progress SHALL complete.

Reset
REQ-036 While RST is 1, the following SHALL hold: phase=0, locked=0, synchroniser cleared, starve_cnt=0, no owners, ram_drive=0, ram_we_n=1, ram_addr=0, ram_dout=0, vid_ack=0, dma_ack=0, vid_rdata=0, dma_rdata=0.
REQ-037 Reset asserted mid-transfer SHALL drop that transfer silently, with no ack. The requester SHALL re-issue it.
REQ-038 After reset, no slot SHALL be granted before locked is set, which takes at least two Gigatron edges.

Structure
REQ-039 The shared package SHALL hold the phase constants (PH_A=0, PH_B=1, PH_G0=2, PH_G1=3), the owner enum (OWN_NONE, OWN_VID, OWN_DMA) and the default STARVE_LIMIT.
REQ-040 SHALL instantiate one sub-module, gclk_phase_tracker, containing the synchroniser, edge detector, phase counter and lock logic. Arbitration and the SRAM port remain in sram_slot_arbiter.

Verification
REQ-041 Lock: with steady CLK, locked SHALL rise after the second edge. Shifting the CLK edge by 1 cycle SHALL drop locked within 1 cycle, and locked SHALL re-acquire after 2 more edges.
REQ-042 Video read: vid_req=1, vid_addr=0x12345, SRAM returns 0xA5. ram_addr SHALL be 0x12345 in slot A, and vid_ack SHALL pulse at phase 1 with vid_rdata=0xA5.
REQ-043 DMA write: dma_we=1, addr=0x7FFFF, wdata=0x3C, no video. ram_we_n SHALL be 0 for exactly phase 0, and dma_ack SHALL pulse at phase 1.
REQ-044 Starvation: with vid_req and dma_req held high, DMA SHALL win slot B within 9 Gigatron cycles, and starve_cnt SHALL clear afterwards.
REQ-045 Reset mid-slot: asserting RST during a slot A read SHALL produce no ack. ram_drive SHALL be 0 on the next cycle, and locked SHALL be 0.
REQ-046 Gigatron phases: under random requests, ram_drive SHALL never be 1 while phase is 2 or 3.
